// File: rtl/mfsk_pkg.sv
// Shared types and constants for the MFSK modulator.
// Contents: FSM state enum and the maximal-length Fibonacci LFSR tap masks for widths 5..16.
package mfsk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int unsigned TAP_W = 16;

  // Feedback tap mask (bit i set = state bit i feeds the XOR) for an LFSR of width w.
  function automatic logic [TAP_W-1:0] tap_mask(input int unsigned w);
    case (w)
      5:       tap_mask = 16'h0014;
      6:       tap_mask = 16'h0030;
      7:       tap_mask = 16'h0060;
      8:       tap_mask = 16'h00B8;
      9:       tap_mask = 16'h0110;
      10:      tap_mask = 16'h0240;
      11:      tap_mask = 16'h0500;
      12:      tap_mask = 16'h0829;
      13:      tap_mask = 16'h100D;
      14:      tap_mask = 16'h2015;
      15:      tap_mask = 16'h6000;
      16:      tap_mask = 16'hD008;
      default: tap_mask = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/mfsk_lfsr.sv
// Fibonacci LFSR used as the internal symbol source.
// Ports: clk, rstb (async active-low), load + seed (seed of zero loads all-ones),
//        step (shift once), state (current register value, MSB is the output bit).
module mfsk_lfsr
  import mfsk_pkg::*;
#(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         load,
  input  logic [W-1:0] seed,
  input  logic         step,
  output logic [W-1:0] state
);

  localparam logic [W-1:0] TAPS = W'(tap_mask(W));

  logic fb;

  assign fb = ^(state & TAPS);

  // All-zero is the lock-up state, so a zero seed is replaced by all-ones.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= '1;
    end else if (load) begin
      state <= (seed == '0) ? '1 : seed;
    end else if (step) begin
      state <= {state[W-2:0], fb};
    end
  end

endmodule

// File: rtl/mfsk_mod.sv
// M-ary FSK square-wave modulator: symbols from the internal LFSR (mode=0) or an
// external valid/ready stream (mode=1), each held SYM_CYC clocks, tone half-period
// BASE_HALF + sym*STEP_HALF, phase-continuous across symbol boundaries.
// Ports: clk, rstb, en, mode, seed_load/seed, din/din_valid/din_ready, fsk_out,
//        ready (symbol boundary strobe), shift (LFSR advanced), lfsr, count, sym, underrun.
module mfsk_mod
  import mfsk_pkg::*;
#(
  parameter int unsigned LFSR_W    = 5,
  parameter int unsigned SYM_BITS  = 1,
  parameter int unsigned CNT_W     = 7,
  parameter int unsigned SYM_CYC   = 100,
  parameter int unsigned BASE_HALF = 8,
  parameter int unsigned STEP_HALF = 2
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                en,
  input  logic                mode,
  input  logic                seed_load,
  input  logic [LFSR_W-1:0]   seed,
  input  logic [SYM_BITS-1:0] din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic                fsk_out,
  output logic                ready,
  output logic                shift,
  output logic [LFSR_W-1:0]   lfsr,
  output logic [CNT_W-1:0]    count,
  output logic [SYM_BITS-1:0] sym,
  output logic                underrun
);

  localparam int unsigned HALF_MAX = BASE_HALF + ((1 << SYM_BITS) - 1) * STEP_HALF;
  localparam int unsigned HALF_W   = $clog2(HALF_MAX + 1);
  localparam int unsigned BIT_W    = $clog2(SYM_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SYM_BITS - 1);

  state_e              state, state_nxt;
  logic                mode_q, mode_q_nxt;
  logic [BIT_W-1:0]    bcnt, bcnt_nxt;
  logic [HALF_W-1:0]   hcnt, hcnt_nxt, half_len_c;
  logic [SYM_BITS-1:0] next_sym, next_sym_nxt, sym_nxt, shifted_c;
  logic                buf_full, buf_full_nxt;
  logic [CNT_W-1:0]    count_nxt;
  logic                fsk_nxt, ready_nxt, shift_nxt, din_ready_nxt, underrun_nxt;
  logic                step_c, seed_load_c, accept_c, wrap_c, boundary_c;

  mfsk_lfsr #(.W(LFSR_W)) u_lfsr (
    .clk   (clk),
    .rstb  (rstb),
    .load  (seed_load_c),
    .seed  (seed),
    .step  (step_c),
    .state (lfsr)
  );

  assign half_len_c = HALF_W'(BASE_HALF) + HALF_W'(sym) * HALF_W'(STEP_HALF);

  // State and registered outputs.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= ST_IDLE;
      mode_q    <= 1'b0;
      bcnt      <= '0;
      hcnt      <= '0;
      next_sym  <= '0;
      buf_full  <= 1'b0;
      count     <= '0;
      sym       <= '0;
      fsk_out   <= 1'b0;
      ready     <= 1'b0;
      shift     <= 1'b0;
      din_ready <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_nxt;
      mode_q    <= mode_q_nxt;
      bcnt      <= bcnt_nxt;
      hcnt      <= hcnt_nxt;
      next_sym  <= next_sym_nxt;
      buf_full  <= buf_full_nxt;
      count     <= count_nxt;
      sym       <= sym_nxt;
      fsk_out   <= fsk_nxt;
      ready     <= ready_nxt;
      shift     <= shift_nxt;
      din_ready <= din_ready_nxt;
      underrun  <= underrun_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    mode_q_nxt    = mode_q;
    bcnt_nxt      = bcnt;
    hcnt_nxt      = hcnt;
    next_sym_nxt  = next_sym;
    buf_full_nxt  = buf_full;
    count_nxt     = count;
    sym_nxt       = sym;
    fsk_nxt       = fsk_out;
    ready_nxt     = 1'b0;
    shift_nxt     = 1'b0;
    din_ready_nxt = 1'b0;
    underrun_nxt  = underrun;
    step_c        = 1'b0;
    seed_load_c   = 1'b0;
    wrap_c        = 1'b0;
    boundary_c    = 1'b0;
    accept_c      = din_valid & din_ready;
    // LFSR output bit appended MSB-first to the symbol being assembled.
    shifted_c     = SYM_BITS'({next_sym, lfsr[LFSR_W-1]});

    case (state)
      ST_IDLE: begin
        seed_load_c  = seed_load;
        count_nxt    = '0;
        hcnt_nxt     = '0;
        fsk_nxt      = 1'b0;
        buf_full_nxt = 1'b0;
        if (en) begin
          state_nxt    = ST_LOAD;
          mode_q_nxt   = mode;
          bcnt_nxt     = '0;
          underrun_nxt = 1'b0;
        end
      end
      ST_LOAD: begin
        if (!mode_q) begin
          step_c       = 1'b1;
          next_sym_nxt = shifted_c;
          bcnt_nxt     = bcnt + BIT_W'(1);
          if (bcnt == BIT_LAST) begin
            state_nxt  = ST_RUN;
            sym_nxt    = shifted_c;
            count_nxt  = '0;
            boundary_c = 1'b1;
          end
        end else if (accept_c) begin
          state_nxt  = ST_RUN;
          sym_nxt    = din;
          count_nxt  = '0;
          boundary_c = 1'b1;
        end
      end
      ST_RUN: begin
        wrap_c     = (count == CNT_LAST);
        boundary_c = wrap_c;
        count_nxt  = wrap_c ? '0 : count + CNT_W'(1);
        if (!mode_q) begin
          // Prefetch the following symbol early in the current one.
          if (count < CNT_W'(SYM_BITS)) begin
            step_c       = 1'b1;
            next_sym_nxt = shifted_c;
          end
          if (wrap_c) sym_nxt = next_sym;
        end else begin
          if (wrap_c) begin
            if (buf_full) begin
              sym_nxt      = next_sym;
              buf_full_nxt = 1'b0;
            end else begin
              underrun_nxt = 1'b1;
            end
          end
          if (accept_c) begin
            next_sym_nxt = din;
            buf_full_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Disable wins from any state; symbol, LFSR and flags are held.
    if (!en) begin
      state_nxt    = ST_IDLE;
      mode_q_nxt   = mode_q;
      bcnt_nxt     = bcnt;
      next_sym_nxt = next_sym;
      sym_nxt      = sym;
      underrun_nxt = underrun;
      step_c       = 1'b0;
      boundary_c   = 1'b0;
      count_nxt    = '0;
      hcnt_nxt     = '0;
      fsk_nxt      = 1'b0;
      buf_full_nxt = 1'b0;
    end

    // Tone generator: the half counter restarts at boundaries without toggling.
    if (state_nxt == ST_RUN) begin
      ready_nxt     = boundary_c;
      din_ready_nxt = mode_q_nxt & ~buf_full_nxt;
      if (boundary_c) begin
        hcnt_nxt = '0;
      end else if (hcnt >= half_len_c - HALF_W'(1)) begin
        hcnt_nxt = '0;
        fsk_nxt  = ~fsk_out;
      end else begin
        hcnt_nxt = hcnt + HALF_W'(1);
      end
    end else if (state_nxt == ST_LOAD) begin
      din_ready_nxt = mode_q_nxt;
    end

    shift_nxt = step_c;
  end

endmodule
